// File: rtl/program_loader.sv
// Boot-time program loader: receives a length-prefixed, checksummed byte stream
// and writes 3-byte big-endian words into instruction memory while holding the CPU in reset.
module program_loader #(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [3:0]        dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LEN_HI = 4'd1,
    S_LEN_LO = 4'd2,
    S_B0     = 4'd3,
    S_B1     = 4'd4,
    S_B2     = 4'd5,
    S_WRITE  = 4'd6,
    S_CHECK  = 4'd7,
    S_DONE   = 4'd8,
    S_ERROR  = 4'd9
  } state_t;

  typedef struct packed {
    logic in_ready;
    logic busy;
    logic done;
    logic error;
    logic cpu_rst;
  } ctl_t;

  // Status flags are a pure function of the state being entered, so they are
  // registered together with the state and never lag it.
  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c.in_ready = (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_B0) ||
                 (s == S_B1) || (s == S_B2) || (s == S_CHECK);
    c.busy     = !((s == S_IDLE) || (s == S_DONE) || (s == S_ERROR));
    c.done     = (s == S_DONE);
    c.error    = (s == S_ERROR);
    c.cpu_rst  = (s != S_DONE);
    return c;
  endfunction

  state_t            state;
  ctl_t              ctl;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] count_r;
  logic [ADDR_W-9:0] len_hi_r;
  logic [WORD_W-17:0] b0_r;
  logic [7:0]        b1_r;
  logic [7:0]        csum;
  logic              xfer;

  // Handshake: a byte moves on a posedge where in_valid && in_ready; in_valid low
  // in a receiving state leaves every register untouched.
  assign xfer = in_valid & ctl.in_ready;

  assign in_ready  = ctl.in_ready;
  assign busy      = ctl.busy;
  assign done      = ctl.done;
  assign error     = ctl.error;
  assign cpu_rst   = ctl.cpu_rst;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ctl        <= ctl_of(S_IDLE);
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cnt        <= '0;
      count_r    <= '0;
      len_hi_r   <= '0;
      b0_r       <= '0;
      b1_r       <= '0;
      csum       <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state <= S_LEN_HI;
            ctl   <= ctl_of(S_LEN_HI);
            cnt   <= '0;
            csum  <= '0;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_hi_r <= in_data[ADDR_W-9:0];
            csum     <= csum ^ in_data;
            state    <= S_LEN_LO;
            ctl      <= ctl_of(S_LEN_LO);
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            count_r <= {len_hi_r, in_data};
            csum    <= csum ^ in_data;
            if ({len_hi_r, in_data} == '0) begin
              state <= S_CHECK;
              ctl   <= ctl_of(S_CHECK);
            end else begin
              state <= S_B0;
              ctl   <= ctl_of(S_B0);
            end
          end
        end
        S_B0: begin
          if (xfer) begin
            b0_r  <= in_data[WORD_W-17:0];
            csum  <= csum ^ in_data;
            state <= S_B1;
            ctl   <= ctl_of(S_B1);
          end
        end
        S_B1: begin
          if (xfer) begin
            b1_r  <= in_data;
            csum  <= csum ^ in_data;
            state <= S_B2;
            ctl   <= ctl_of(S_B2);
          end
        end
        S_B2: begin
          if (xfer) begin
            imem_we    <= 1'b1;
            imem_addr  <= cnt;
            imem_wdata <= {b0_r, b1_r, in_data};
            csum       <= csum ^ in_data;
            state      <= S_WRITE;
            ctl        <= ctl_of(S_WRITE);
          end
        end
        S_WRITE: begin
          // cnt only advances after a write, so COUNT = 2^ADDR_W-1 ends at the top value without wrapping.
          cnt <= cnt + ADDR_W'(1);
          if (cnt == count_r - ADDR_W'(1)) begin
            state <= S_CHECK;
            ctl   <= ctl_of(S_CHECK);
          end else begin
            state <= S_B0;
            ctl   <= ctl_of(S_B0);
          end
        end
        S_CHECK: begin
          if (xfer) begin
            if (in_data == csum) begin
              state <= S_DONE;
              ctl   <= ctl_of(S_DONE);
            end else begin
              state <= S_ERROR;
              ctl   <= ctl_of(S_ERROR);
            end
          end
        end
        default: begin
          state <= S_IDLE;
          ctl   <= ctl_of(S_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a stream-level model predicts every memory
// write and the final status, and a negedge monitor checks the DUT against it.
module tb_program_loader;

  localparam int ADDR_W = 12;
  localparam int WORD_W = 19;

  typedef logic [7:0] byte_q_t[$];

  logic              clk;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              error;
  logic [3:0]        dbg_state;

  program_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .error(error), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [ADDR_W+WORD_W-1:0] exp_q[$];
  logic [ADDR_W+WORD_W-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stream-level model: length field, 3-byte words, XOR checksum.
  task automatic model_load(input byte_q_t s, output bit ok);
    int count;
    logic [7:0] cs;
    logic [23:0] w;
    count = int'({s[0], s[1]}) % (1 << ADDR_W);
    cs = 8'h00;
    for (int i = 0; i < 2 + 3 * count; i++) cs = cs ^ s[i];
    for (int i = 0; i < count; i++) begin
      w = {s[2 + 3 * i], s[3 + 3 * i], s[4 + 3 * i]};
      exp_q.push_back({ADDR_W'(i), w[WORD_W-1:0]});
    end
    ok = (s[2 + 3 * count] == cs);
  endtask

  task automatic make_stream(input int n, input logic [7:0] hi_pad, output byte_q_t s);
    logic [7:0] cs;
    s = {};
    s.push_back(hi_pad | 8'(n >> 8));
    s.push_back(8'(n & 255));
    for (int i = 0; i < 3 * n; i++) s.push_back(8'($urandom));
    cs = 8'h00;
    foreach (s[i]) cs = cs ^ s[i];
    s.push_back(cs);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (imem_we) begin
        check("in_ready_during_write", 32'(in_ready), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", 32'(imem_addr), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr", 32'(imem_addr), 32'(mon_e[WORD_W +: ADDR_W]));
          check("write_data", 32'(imem_wdata), 32'(mon_e[WORD_W-1:0]));
        end
      end
      if (done) begin
        check("done_cpu_rst", 32'(cpu_rst), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
      end
      if (error) begin
        check("error_cpu_rst", 32'(cpu_rst), 32'd1);
        check("error_busy", 32'(busy), 32'd0);
      end
      if (in_ready) check("ready_implies_busy", 32'(busy), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input byte_q_t s, input int n_bytes, input bit stall, input int start_at);
    int guard;
    for (int i = 0; i < n_bytes; i++) begin
      if (i == start_at) begin
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if (stall) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_data = 8'($urandom);
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data = s[i];
      guard = 0;
      while (!in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        check("send_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 8'h00;
  endtask

  task automatic wait_end(input bit exp_ok);
    int g;
    g = 0;
    while (!(done || error) && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("end_done", 32'(done), 32'(exp_ok));
    check("end_error", 32'(error), 32'(!exp_ok));
    check("end_cpu_rst", 32'(cpu_rst), 32'(!exp_ok));
    check("end_busy", 32'(busy), 32'd0);
    check("end_in_ready", 32'(in_ready), 32'd0);
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, 32'(imem_wdata), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    byte_q_t s;
    bit ok;
    logic [ADDR_W+WORD_W-1:0] last_e;

    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_hold_busy", 32'(busy), 32'd0);
    check("idle_hold_in_ready", 32'(in_ready), 32'd0);

    // Single word
    s = '{8'h00, 8'h01, 8'h07, 8'hFF, 8'hFF, 8'h06};
    model_load(s, ok);
    check("model_single_ok", 32'(ok), 32'd1);
    check("model_single_word", 32'(exp_q[0]), 32'({12'h000, 19'h7FFFF}));
    pulse_start();
    send(s, s.size(), 1'b0, -1);
    wait_end(ok);

    // Empty program
    s = '{8'h00, 8'h00, 8'h00};
    model_load(s, ok);
    check("model_empty_writes", 32'(exp_q.size()), 32'd0);
    pulse_start();
    send(s, s.size(), 1'b0, -1);
    wait_end(ok);

    // Bad checksum, then restart from ERROR
    s = '{8'h00, 8'h01, 8'h07, 8'hFF, 8'hFF, 8'h07};
    model_load(s, ok);
    check("model_bad_ok", 32'(ok), 32'd0);
    pulse_start();
    send(s, s.size(), 1'b0, -1);
    wait_end(ok);
    pulse_start();
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_error", 32'(error), 32'd0);
    check("restart_cpu_rst", 32'(cpu_rst), 32'd1);
    do_reset();

    // Three words under random back-pressure
    make_stream(3, 8'h00, s);
    model_load(s, ok);
    pulse_start();
    send(s, s.size(), 1'b1, -1);
    wait_end(ok);

    // Reset after B1 of the second word, then a clean load
    make_stream(2, 8'h00, s);
    model_load(s, ok);
    pulse_start();
    send(s, 7, 1'b0, -1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midload");
    check("midload_pending_writes", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_idle_busy", 32'(busy), 32'd0);
    check("post_rst_idle_ready", 32'(in_ready), 32'd0);
    make_stream(2, 8'h00, s);
    model_load(s, ok);
    pulse_start();
    send(s, s.size(), 1'b0, -1);
    wait_end(ok);

    // start pulsed mid-load, with ignored upper LEN_HI bits
    make_stream(2, 8'hF0, s);
    model_load(s, ok);
    check("model_hi_pad_writes", 32'(exp_q.size()), 32'd2);
    pulse_start();
    send(s, s.size(), 1'b1, 3);
    wait_end(ok);

    // Maximum COUNT: addresses 0 .. 2^ADDR_W-2
    make_stream((1 << ADDR_W) - 1, 8'h00, s);
    model_load(s, ok);
    last_e = exp_q[exp_q.size() - 1];
    check("model_max_last_addr", 32'(last_e[WORD_W +: ADDR_W]), 32'h0000_0FFE);
    pulse_start();
    send(s, s.size(), 1'b0, -1);
    wait_end(ok);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, instruction memory address width.
REQ-002 SHALL have parameter WORD_W, default 19, instruction word width; the byte mapping in REQ-017 is defined for 17..24.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  single-cycle load request.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream data.
REQ-008 in_ready  output  1  byte-stream ready; a byte transfers on a posedge where in_valid and in_ready are both 1.
REQ-009 imem_we  output  1  instruction memory write strobe.
REQ-010 imem_addr  output  ADDR_W  instruction memory write address.
REQ-011 imem_wdata  output  WORD_W  instruction memory write data.
REQ-012 cpu_rst  output  1  holds the processor in reset while high.
REQ-013 busy / done / error  output  1 each  status flags.

Function
REQ-014 SHALL implement states IDLE, LEN_HI, LEN_LO, B0, B1, B2, WRITE, CHECK, DONE, ERROR.
REQ-015 Stream format SHALL be: LEN_HI, LEN_LO, then COUNT words of 3 bytes each, then 1 checksum byte; COUNT = {LEN_HI[ADDR_W-9:0], LEN_LO}, and the unused upper bits of LEN_HI are ignored.
REQ-016 in_ready SHALL be 1 only in LEN_HI, LEN_LO, B0, B1, B2 and CHECK; it SHALL be 0 in IDLE, WRITE, DONE and ERROR.
REQ-017 Word assembly SHALL be big-endian: B0[WORD_W-17:0] maps to word[WORD_W-1:16], B1 to word[15:8] and B2 to word[7:0]; unused B0 bits are ignored.
REQ-018 IDLE, DONE and ERROR with start=1 SHALL go to LEN_HI, clear the address counter and checksum, clear done and error, and set cpu_rst=1.
REQ-019 start SHALL be ignored in all other states.
REQ-020 LEN_LO on transfer SHALL go to CHECK if COUNT==0, and to B0 otherwise.
REQ-021 B0 to B1 and B1 to B2 SHALL advance only on a transfer; B2 on transfer SHALL go to WRITE.
REQ-022 WRITE SHALL last exactly 1 cycle with imem_we=1, imem_addr=current counter value and imem_wdata=assembled word, all registered.
REQ-023 WRITE SHALL increment the counter afterwards, then go to CHECK if the word just written was word COUNT-1, and to B0 otherwise.
REQ-024 The first word SHALL be written to address 0; write latency from the B2 transfer edge to the imem_we high cycle SHALL be 1 cycle.
REQ-025 The checksum SHALL be the XOR of every transferred byte from LEN_HI through the last B2, starting from 0.
REQ-026 In CHECK, a received byte equal to the checksum SHALL go to DONE; any other value SHALL go to ERROR.
REQ-027 DONE SHALL drive done=1, cpu_rst=0 and busy=0.
REQ-028 ERROR SHALL drive error=1, cpu_rst=1 and busy=0.
REQ-029 busy SHALL be 1 in every state from LEN_HI through CHECK.
REQ-030 imem_we SHALL be 0 in every state except WRITE.
REQ-031 in_valid=0 in any receiving state SHALL hold the state with no side effects (stall-tolerant).
REQ-032 COUNT of 2^ADDR_W-1 SHALL write addresses 0 through 2^ADDR_W-2 with no counter wrap.

Reset
REQ-033 Asserting rst at any time, including mid-load, SHALL immediately put the block in IDLE.
REQ-034 Reset values SHALL be: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, cpu_rst=1, counter=0, checksum=0.
REQ-035 Words already written before a reset SHALL NOT be retracted.
REQ-036 After rst deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-037 Single word: start; bytes 00 01 07 FF FF 06 -> one imem_we pulse with addr=0x000, wdata=0x7FFFF; then done=1, cpu_rst=0, error=0.
REQ-038 Empty program: start; bytes 00 00 00 -> no imem_we pulse; done=1.
REQ-039 Bad checksum: bytes 00 01 07 FF FF 07 -> imem_we pulse at addr 0, then error=1, cpu_rst=1, done=0; a further start -> busy=1, error=0.
REQ-040 Back-pressure: three words with in_valid toggled randomly -> writes to addresses 0, 1, 2 in order with correct data; in_ready=0 during each WRITE cycle; done=1.
REQ-041 Reset mid-load: rst pulse after B1 of word 2 -> immediate IDLE, all outputs at reset values, cpu_rst=1; a new complete load then succeeds from address 0.
REQ-042 start pulsed while busy -> ignored; the load completes unchanged.
